// File: rtl/dac_stream_pkg.sv
// Shared types and helpers for the DAC sample streamer.
package dac_stream_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_PACED  = 2'd1,
    MODE_RAMP   = 2'd2
  } mode_e;

  localparam logic [1:0] CFG_MODE_RSVD = 2'd3;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned chan_w(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Synchronous sample FIFO with flush; a push in the flush cycle lands in the emptied FIFO.
module dac_sample_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata_c,
  output logic                     o_full_c,
  output logic                     o_empty_c,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_widx;

  assign o_full_c  = (r_level == LW'(DEPTH));
  assign o_empty_c = (r_level == '0);
  assign w_push    = i_push & (i_flush | ~o_full_c);
  assign w_pop     = i_pop & ~o_empty_c & ~i_flush;
  assign w_widx    = i_flush ? '0 : r_wptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      r_rptr  <= '0;
      r_wptr  <= AW'(w_push);
      r_level <= LW'(w_push);
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  // Storage needs no reset: entries are only read once level covers them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_widx] <= i_wdata;
  end

  assign o_rdata_c = r_mem[r_rptr];
  assign o_level   = r_level;

endmodule

// File: rtl/dac_stream_ctrl.sv
// Paced/direct/ramp sample streamer from the core to NCH DAC input registers.
module dac_stream_ctrl
  import dac_stream_pkg::*;
#(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned NCH        = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 8,
  parameter int unsigned RESET_CODE = 512
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [1:0]                    cfg_mode,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [chan_w(NCH)-1:0]        wr_ch,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [NCH*DATA_W-1:0]         D,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          bad_ch,
  input  logic                          clr_flags
);

  localparam int unsigned CW = chan_w(NCH);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FW = CW + DATA_W;

  mode_e             r_mode;
  mode_e             w_mode;
  logic              w_mode_chg;
  logic [DIV_W-1:0]  r_cnt;
  logic [DIV_W-1:0]  w_cnt_nxt;
  logic              w_tick;
  logic              r_wr_ready;
  logic              w_ready_nxt;
  logic              w_accept;
  logic              w_direct_wr;
  logic              w_push;
  logic              w_pop;
  logic              w_ramp_step;
  logic              w_under_set;
  logic              w_bad_set;
  logic [LW-1:0]     w_level;
  logic [LW-1:0]     w_level_nxt;
  logic              w_full_c;
  logic              w_empty_c;
  logic [FW-1:0]     w_head_c;
  logic [CW-1:0]     w_head_ch;
  logic [DATA_W-1:0] w_head_data;
  logic [DATA_W-1:0] r_d [NCH];
  logic              r_underrun;
  logic              r_bad_ch;

  // Mode state register: remembers last cycle's mode to detect changes.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) r_mode <= MODE_DIRECT;
    else        r_mode <= w_mode;
  end

  always_comb begin
    w_mode = MODE_DIRECT;
    unique case (cfg_mode)
      2'd1:          w_mode = MODE_PACED;
      2'd2:          w_mode = MODE_RAMP;
      CFG_MODE_RSVD: w_mode = MODE_DIRECT;
      default:       w_mode = MODE_DIRECT;
    endcase
  end

  assign w_mode_chg = (w_mode != r_mode);

  // Sample-rate divider; >= keeps it bounded if cfg_div shrinks mid-count.
  always_comb begin
    w_tick    = 1'b0;
    w_cnt_nxt = r_cnt;
    if (!enable || w_mode_chg) begin
      w_cnt_nxt = '0;
    end else if (r_cnt >= cfg_div) begin
      w_tick    = 1'b1;
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) r_cnt <= '0;
    else        r_cnt <= w_cnt_nxt;
  end

  assign w_head_ch   = w_head_c[DATA_W +: CW];
  assign w_head_data = w_head_c[DATA_W-1:0];
  assign w_accept    = wr_valid & r_wr_ready;

  // Per-mode actions; the pop/underrun decision uses pre-edge FIFO state.
  always_comb begin
    w_direct_wr = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_ramp_step = 1'b0;
    w_under_set = 1'b0;
    unique case (w_mode)
      MODE_DIRECT: w_direct_wr = w_accept;
      MODE_PACED: begin
        w_push      = w_accept & (~w_full_c | w_mode_chg);
        w_pop       = w_tick & ~w_empty_c;
        w_under_set = w_tick & w_empty_c;
      end
      MODE_RAMP:   w_ramp_step = w_tick;
      default:     w_direct_wr = 1'b0;
    endcase
    w_bad_set = (w_direct_wr & (32'(wr_ch) >= NCH)) |
                (w_pop & (32'(w_head_ch) >= NCH));
    w_level_nxt = w_mode_chg ? LW'(w_push)
                             : w_level + LW'(w_push) - LW'(w_pop);
    w_ready_nxt = (w_mode == MODE_DIRECT) |
                  ((w_mode == MODE_PACED) & (w_level_nxt != LW'(FIFO_DEPTH)));
  end

  dac_sample_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (reset),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_flush   (w_mode_chg),
    .i_wdata   ({wr_ch, wr_data}),
    .o_rdata_c (w_head_c),
    .o_full_c  (w_full_c),
    .o_empty_c (w_empty_c),
    .o_level   (w_level)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_wr_ready <= 1'b0;
      r_underrun <= 1'b0;
      r_bad_ch   <= 1'b0;
    end else begin
      r_wr_ready <= w_ready_nxt;
      r_underrun <= w_under_set | (r_underrun & ~clr_flags);
      r_bad_ch   <= w_bad_set | (r_bad_ch & ~clr_flags);
    end
  end

  // Per-channel DAC code registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NCH; k++) r_d[k] <= DATA_W'(RESET_CODE);
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_ramp_step)
          r_d[k] <= r_d[k] + DATA_W'(1);
        else if (w_direct_wr && (32'(wr_ch) == 32'(k)))
          r_d[k] <= wr_data;
        else if (w_pop && (32'(w_head_ch) == 32'(k)))
          r_d[k] <= w_head_data;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_dout
    assign D[g*DATA_W +: DATA_W] = r_d[g];
  end

  assign wr_ready   = r_wr_ready;
  assign fifo_level = w_level;
  assign underrun   = r_underrun;
  assign bad_ch     = r_bad_ch;

endmodule

// File: tb/tb_dac_stream_ctrl.sv
// Directed bench for dac_stream_ctrl: NCH=2 main instance plus an NCH=3 instance for channel-range errors.
module tb_dac_stream_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_div;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_ch;
  logic [9:0]  wr_data;
  logic [19:0] d;
  logic [3:0]  fifo_level;
  logic        underrun;
  logic        bad_ch;
  logic        clr_flags;

  logic        wr_valid3;
  logic        wr_ready3;
  logic [1:0]  wr_ch3;
  logic [9:0]  wr_data3;
  logic [29:0] d3;
  logic [3:0]  fifo_level3;
  logic        underrun3;
  logic        bad_ch3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dac_stream_ctrl u_dut (
    .CLK        (clk),
    .reset      (reset),
    .enable     (enable),
    .cfg_mode   (cfg_mode),
    .cfg_div    (cfg_div),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_ch      (wr_ch),
    .wr_data    (wr_data),
    .D          (d),
    .fifo_level (fifo_level),
    .underrun   (underrun),
    .bad_ch     (bad_ch),
    .clr_flags  (clr_flags)
  );

  dac_stream_ctrl #(.NCH(3)) u_dut3 (
    .CLK        (clk),
    .reset      (reset),
    .enable     (enable),
    .cfg_mode   (cfg_mode),
    .cfg_div    (cfg_div),
    .wr_valid   (wr_valid3),
    .wr_ready   (wr_ready3),
    .wr_ch      (wr_ch3),
    .wr_data    (wr_data3),
    .D          (d3),
    .fifo_level (fifo_level3),
    .underrun   (underrun3),
    .bad_ch     (bad_ch3),
    .clr_flags  (clr_flags)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset     = 1'b0;
    clr_flags = 1'b0;
    wr_valid3 = 1'b0;
    wr_ch3    = 2'd0;
    wr_data3  = 10'd0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      enable    = 1'($urandom);
      cfg_mode  = 2'($urandom);
      cfg_div   = 8'($urandom);
      wr_valid  = 1'($urandom);
      wr_ch     = 1'($urandom);
      wr_data   = 10'($urandom);
      clr_flags = 1'($urandom);
      wr_valid3 = 1'($urandom);
      step(1);
    end
    check_eq("rst_d0", 32'(d[9:0]), 32'd512);
    check_eq("rst_d1", 32'(d[19:10]), 32'd512);
    check_eq("rst_ready", 32'(wr_ready), 32'd0);
    check_eq("rst_level", 32'(fifo_level), 32'd0);
    check_eq("rst_flags", 32'({underrun, bad_ch}), 32'd0);

    enable    = 1'b0;
    cfg_mode  = 2'd0;
    cfg_div   = 8'd0;
    wr_valid  = 1'b0;
    wr_ch     = 1'b0;
    wr_data   = 10'd0;
    clr_flags = 1'b0;
    wr_valid3 = 1'b0;
    reset     = 1'b1;
    #1;
    check_eq("rel_ready_pre", 32'(wr_ready), 32'd0);
    step(1);
    check_eq("rel_ready_direct", 32'(wr_ready), 32'd1);

    // DIRECT write to ch1, one-cycle latency
    wr_valid = 1'b1; wr_ch = 1'b1; wr_data = 10'h3FF;
    step(1);
    wr_valid = 1'b0;
    check_eq("direct_d1", 32'(d[19:10]), 32'h3FF);
    check_eq("direct_d0", 32'(d[9:0]), 32'd512);

    // PACED: fill with 1..8 while divider idle
    cfg_mode = 2'd1; cfg_div = 8'd3; enable = 1'b0;
    step(1);
    check_eq("paced_ready", 32'(wr_ready), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      wr_valid = 1'b1; wr_ch = 1'b0; wr_data = 10'(k);
      step(1);
    end
    wr_valid = 1'b0;
    check_eq("full_level", 32'(fifo_level), 32'd8);
    check_eq("full_ready", 32'(wr_ready), 32'd0);
    check_eq("full_d0", 32'(d[9:0]), 32'd512);

    enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(3);
      check_eq("pace_hold", 32'(d[9:0]), (k == 1) ? 32'd512 : 32'(k - 1));
      step(1);
      check_eq("pace_step", 32'(d[9:0]), 32'(k));
      check_eq("pace_level", 32'(fifo_level), 32'(8 - k));
    end
    step(3);
    check_eq("pre_underrun", 32'(underrun), 32'd0);
    step(1);
    check_eq("underrun_set", 32'(underrun), 32'd1);
    check_eq("underrun_dhold", 32'(d[9:0]), 32'd8);

    // clr_flags alone clears; clr with a same-cycle underrun keeps it set
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check_eq("clr_underrun", 32'(underrun), 32'd0);
    step(2);
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check_eq("clr_vs_set", 32'(underrun), 32'd1);

    // Level 5 then switch to DIRECT flushes
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wr_valid = 1'b1; wr_ch = 1'b1; wr_data = 10'(16'h100 + k);
      step(1);
    end
    wr_valid = 1'b0;
    check_eq("lvl5", 32'(fifo_level), 32'd5);
    cfg_mode = 2'd0;
    step(1);
    check_eq("flush_level", 32'(fifo_level), 32'd0);
    check_eq("flush_d0", 32'(d[9:0]), 32'd8);
    check_eq("flush_d1", 32'(d[19:10]), 32'h3FF);
    check_eq("flush_ready", 32'(wr_ready), 32'd1);

    // Out-of-range channel on the NCH=3 instance
    wr_valid3 = 1'b1; wr_ch3 = 2'd3; wr_data3 = 10'h055;
    step(1);
    wr_valid3 = 1'b0;
    check_eq("badch_flag", 32'(bad_ch3), 32'd1);
    check_eq("badch_dhold", 32'(d3), {2'b00, 10'd512, 10'd512, 10'd512});
    check_eq("badch_main", 32'(bad_ch), 32'd0);
    wr_valid3 = 1'b1; wr_ch3 = 2'd2; wr_data3 = 10'h055;
    step(1);
    wr_valid3 = 1'b0;
    check_eq("ch2_write", 32'(d3[29:20]), 32'h055);
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check_eq("badch_clr", 32'(bad_ch3), 32'd0);
    check_eq("underrun_clr", 32'(underrun), 32'd0);

    // RAMP wrap from 0x3FE on both channels
    wr_valid = 1'b1; wr_ch = 1'b0; wr_data = 10'h3FE;
    step(1);
    wr_ch = 1'b1;
    step(1);
    wr_valid = 1'b0;
    cfg_mode = 2'd2; cfg_div = 8'd0; enable = 1'b1;
    step(1);
    check_eq("ramp_chg", 32'(d), {12'd0, 10'h3FE, 10'h3FE});
    check_eq("ramp_ready", 32'(wr_ready), 32'd0);
    step(1);
    check_eq("ramp_3ff", 32'(d), {12'd0, 10'h3FF, 10'h3FF});
    step(1);
    check_eq("ramp_000", 32'(d), 32'd0);
    step(1);
    check_eq("ramp_001", 32'(d), {12'd0, 10'h001, 10'h001});

    // Asynchronous reset mid-operation
    reset = 1'b0;
    #1;
    check_eq("arst_d", 32'(d), {12'd0, 10'd512, 10'd512});
    check_eq("arst_ready", 32'(wr_ready), 32'd0);
    check_eq("arst_level", 32'(fifo_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
